// File: rtl/psum_ctrl_pkg.sv
// Shared definitions for the psum accumulation FIFO sequencer:
// state encoding, flush length and the pointer-width legality check.
package psum_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLR   = 3'd1,
      ACCUM = 3'd2,
      FLUSH = 3'd3,
      DRAIN = 3'd4,
      DONE  = 3'd5
   } state_t;

   // Cycles needed for the 2-stage write alignment pipe to empty.
   localparam int FLUSH_CYCLES = 2;

   // Pointer/counter width must be able to address every FIFO entry.
   function automatic bit add_width_ok(input int add_width, input int fifo_size);
      return (2 ** add_width) >= fifo_size;
   endfunction

endpackage

// File: rtl/psum_fifo_ctrl_if.sv
// Bus between the psum FIFO sequencer and its environment (PE array
// input side, FIFO control side, drained result side).
interface psum_fifo_ctrl_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADD_WIDTH  = 4,
   parameter int PASS_WIDTH = 8
);
   logic                  start;
   logic [PASS_WIDTH-1:0] num_passes;
   logic [ADD_WIDTH-1:0]  row_len;
   logic                  psum_valid;
   logic [DATA_WIDTH-1:0] psum_in;
   logic [DATA_WIDTH-1:0] fifo_dout;
   logic                  fifo_wr_clr;
   logic                  fifo_rd_clr;
   logic                  fifo_wr_en;
   logic                  fifo_rd_en;
   logic                  fifo_wr_inc;
   logic                  fifo_rd_inc;
   logic                  fifo_re_buf;
   logic [DATA_WIDTH-1:0] fifo_din;
   logic                  out_valid;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  busy;
   logic                  done;
   logic                  ovf_err;

   modport master (
      output start, num_passes, row_len, psum_valid, psum_in, fifo_dout,
      input  fifo_wr_clr, fifo_rd_clr, fifo_wr_en, fifo_rd_en, fifo_wr_inc,
             fifo_rd_inc, fifo_re_buf, fifo_din, out_valid, out_data,
             busy, done, ovf_err
   );

   modport slave (
      input  start, num_passes, row_len, psum_valid, psum_in, fifo_dout,
      output fifo_wr_clr, fifo_rd_clr, fifo_wr_en, fifo_rd_en, fifo_wr_inc,
             fifo_rd_inc, fifo_re_buf, fifo_din, out_valid, out_data,
             busy, done, ovf_err
   );
endinterface

// File: rtl/psum_align_pipe.sv
// Two-stage alignment pipe: an accepted psum at cycle t shows its
// accumulate select at t+1 (with the FIFO read) and its write at t+2.
module psum_align_pipe #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  in_vld,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_re_buf,
   output logic                  re_buf,
   output logic                  wr_en,
   output logic [DATA_WIDTH-1:0] din
);
   logic [1:0]                 vld_pipe;
   logic [1:0][DATA_WIDTH-1:0] data_pipe;
   logic                       re_buf_q;

   // Shift valid/data two stages; data is captured only on valid input.
   always_ff @(posedge clk) begin
      if (clr) begin
         vld_pipe  <= '0;
         data_pipe <= '0;
         re_buf_q  <= 1'b0;
      end else begin
         vld_pipe     <= {vld_pipe[0], in_vld};
         if (in_vld)
            data_pipe[0] <= in_data;
         data_pipe[1] <= data_pipe[0];
         re_buf_q     <= in_vld & in_re_buf;
      end
   end

   assign re_buf = re_buf_q;
   assign wr_en  = vld_pipe[1];
   assign din    = data_pipe[1];
endmodule

// File: rtl/psum_fifo_ctrl.sv
// Sequencer for the psum accumulation FIFO at the end of the PE array.
// Runs num_passes passes of row_len psums (pass 0 writes, later passes
// accumulate), then drains the row. Optional macro PSUM_CTRL_RELU_EN
// clamps negative drained results to zero.
module psum_fifo_ctrl
   import psum_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_SIZE  = 10,
   parameter int ADD_WIDTH  = 4,
   parameter int PASS_WIDTH = 8
) (
   input logic             clk1,
   input logic             clr,
   psum_fifo_ctrl_if.slave bus
);
   if (!add_width_ok(ADD_WIDTH, FIFO_SIZE)) begin : g_cfg_err
      $error("ADD_WIDTH too small to address FIFO_SIZE entries");
   end

   localparam logic [ADD_WIDTH-1:0] FSZ    = ADD_WIDTH'(FIFO_SIZE);
   localparam logic [ADD_WIDTH-1:0] FL_END = ADD_WIDTH'(FLUSH_CYCLES - 1);

   state_t                state, state_n;
   logic [ADD_WIDTH-1:0]  cnt, cnt_n, len, len_n;
   logic [PASS_WIDTH-1:0] pass, pass_n, npass, npass_n;
   logic                  ovf, ovf_n;
   logic                  accept, drain_rd;
   logic                  wr_clr_q, rd_clr_q, rd_en_q, drain_rd_q;
   logic                  out_valid_q, done_q, busy_q;
   logic                  pipe_wr_en;

   // State and counter registers; outputs are registered off next state
   // so each one is high exactly during the state it belongs to.
   always_ff @(posedge clk1) begin
      if (clr) begin
         state       <= IDLE;
         cnt         <= '0;
         len         <= '0;
         pass        <= '0;
         npass       <= '0;
         ovf         <= 1'b0;
         wr_clr_q    <= 1'b0;
         rd_clr_q    <= 1'b0;
         rd_en_q     <= 1'b0;
         drain_rd_q  <= 1'b0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         len         <= len_n;
         pass        <= pass_n;
         npass       <= npass_n;
         ovf         <= ovf_n;
         wr_clr_q    <= (state_n == CLR);
         rd_clr_q    <= (state_n == CLR) || (state_n == DRAIN && cnt_n == '0);
         rd_en_q     <= drain_rd || (accept && pass != '0);
         drain_rd_q  <= drain_rd;
         out_valid_q <= drain_rd_q;
         done_q      <= (state_n == DONE);
         busy_q      <= (state_n != IDLE);
      end
   end

   // Next-state, counters, sampled row parameters and error flag.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      len_n   = len;
      pass_n  = pass;
      npass_n = npass;
      ovf_n   = ovf;
      accept  = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               state_n = CLR;
               pass_n  = '0;
               ovf_n   = 1'b0;
               npass_n = (bus.num_passes == '0) ? PASS_WIDTH'(1) : bus.num_passes;
               if (bus.row_len == '0)
                  len_n = ADD_WIDTH'(1);
               else if (bus.row_len > FSZ) begin
                  len_n = FSZ;
                  ovf_n = 1'b1;
               end else
                  len_n = bus.row_len;
            end else if (bus.psum_valid)
               ovf_n = 1'b1;
         end
         CLR: begin
            cnt_n   = '0;
            state_n = ACCUM;
         end
         ACCUM: begin
            if (bus.psum_valid) begin
               accept = 1'b1;
               cnt_n  = cnt + ADD_WIDTH'(1);
               if (cnt + ADD_WIDTH'(1) == len) begin
                  state_n = FLUSH;
                  cnt_n   = '0;
               end
            end
         end
         FLUSH: begin
            if (bus.psum_valid)
               ovf_n = 1'b1;
            cnt_n = cnt + ADD_WIDTH'(1);
            if (cnt == FL_END) begin
               cnt_n = '0;
               if ((pass + PASS_WIDTH'(1)) < npass) begin
                  pass_n  = pass + PASS_WIDTH'(1);
                  state_n = CLR;
               end else
                  state_n = DRAIN;
            end
         end
         DRAIN: begin
            if (bus.psum_valid)
               ovf_n = 1'b1;
            if (cnt == len)
               state_n = DONE;
            else
               cnt_n = cnt + ADD_WIDTH'(1);
         end
         DONE: begin
            if (bus.psum_valid)
               ovf_n = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Drain reads follow the rd-pointer clear cycle (cnt 0).
   assign drain_rd = (state_n == DRAIN) && (cnt_n != '0);

   psum_align_pipe #(.DATA_WIDTH(DATA_WIDTH)) u_pipe (
      .clk       (clk1),
      .clr       (clr),
      .in_vld    (accept),
      .in_data   (bus.psum_in),
      .in_re_buf (pass != '0),
      .re_buf    (bus.fifo_re_buf),
      .wr_en     (pipe_wr_en),
      .din       (bus.fifo_din)
   );

   assign bus.fifo_wr_clr = wr_clr_q;
   assign bus.fifo_rd_clr = rd_clr_q;
   assign bus.fifo_wr_en  = pipe_wr_en;
   assign bus.fifo_wr_inc = pipe_wr_en;
   assign bus.fifo_rd_en  = rd_en_q;
   assign bus.fifo_rd_inc = rd_en_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.done        = done_q;
   assign bus.busy        = busy_q;
   assign bus.ovf_err     = ovf;

`ifdef PSUM_CTRL_RELU_EN
   assign bus.out_data = (out_valid_q && bus.fifo_dout[DATA_WIDTH-1]) ? '0 : bus.fifo_dout;
`else
   assign bus.out_data = bus.fifo_dout;
`endif
endmodule

// File: tb/tb_psum_fifo_ctrl.sv
// Bench for psum_fifo_ctrl with a behavioural accumulation FIFO
// (registered read data, registered accumulate select) on the same clock.
module tb_psum_fifo_ctrl;
   localparam int DW = 16, FS = 10, AW = 4, PW = 8;

   logic clk1 = 1'b0;
   logic clr  = 1'b1;
   always #5 clk1 = ~clk1;

   psum_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADD_WIDTH(AW), .PASS_WIDTH(PW)) bus ();
   psum_fifo_ctrl #(.DATA_WIDTH(DW), .FIFO_SIZE(FS), .ADD_WIDTH(AW), .PASS_WIDTH(PW))
      dut (.clk1(clk1), .clr(clr), .bus(bus));

   // Accumulation FIFO model
   logic [DW-1:0] mem [FS];
   int            wptr = 0, rptr = 0;
   logic          rebuf_q = 1'b0;
   logic [DW-1:0] rdata = '0;
   assign bus.fifo_dout = rdata;
   always @(posedge clk1) begin
      rebuf_q <= bus.fifo_re_buf;
      if (bus.fifo_wr_clr) wptr <= 0;
      else if (bus.fifo_wr_en) begin
         mem[wptr] <= rebuf_q ? rdata + bus.fifo_din : bus.fifo_din;
         if (bus.fifo_wr_inc) wptr <= (wptr + 1) % FS;
      end
      if (bus.fifo_rd_clr) rptr <= 0;
      else if (bus.fifo_rd_en) begin
         rdata <= mem[rptr];
         if (bus.fifo_rd_inc) rptr <= (rptr + 1) % FS;
      end
   end

   int  n_vec = 0, n_err = 0, cyc = 0, done_cnt = 0;
   int  vec [3][10];
   int  exp_q[$], got[$];
   bit  chk_en = 0, cur_acc = 0, prev_done = 0;
   int  cur_pass = 0;
   bit  h1 = 0, h2 = 0;
   int  hp1 = 0;
   logic [DW-1:0] hd1 = '0, hd2 = '0;

   always @(posedge clk1) cyc++;

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic int got_at(input int i);
      return (i < got.size()) ? got[i] : -99999;
   endfunction

   // Per-cycle compare against the model: write/read alignment of every
   // accepted psum, drained results against the scoreboard, done pulse.
   always @(negedge clk1) begin
      if (chk_en) begin
         chk("wr_en_align", bus.fifo_wr_en, h2);
         chk("wr_inc_align", bus.fifo_wr_inc, h2);
         if (h2) chk("din", int'($signed(bus.fifo_din)), int'($signed(hd2)));
         if (h1) begin
            chk("rd_en_accum", bus.fifo_rd_en, hp1 > 0);
            chk("re_buf", bus.fifo_re_buf, hp1 > 0);
         end
         if (bus.out_valid) begin
            if (exp_q.size() == 0) chk("out_extra", 1, 0);
            else chk("out_data", int'($signed(bus.out_data)), exp_q.pop_front());
            got.push_back(int'($signed(bus.out_data)));
         end
         if (bus.done) begin
            chk("done_width", prev_done, 0);
            chk("busy_at_done", bus.busy, 1);
            done_cnt++;
         end
      end
      prev_done = bus.done;
      h2 = h1; hd2 = hd1;
      h1 = cur_acc; hd1 = bus.psum_in; hp1 = cur_pass;
      if (clr) begin h1 = 0; h2 = 0; end
   end

   task automatic tick();
      @(posedge clk1); #1;
   endtask

   task automatic drive_pass(input int p, input int n_send, input int L, input bit gap,
                             output int t_last);
      t_last = cyc;
      cur_pass = p;
      for (int k = 0; k < n_send; k++) begin
         bus.psum_valid = 1'b1;
         bus.psum_in    = DW'(vec[p][k]);
         cur_acc        = (k < L);
         if (k == L - 1) t_last = cyc;
         tick();
         if (gap) begin
            bus.psum_valid = 1'b0; cur_acc = 0;
            tick();
         end
      end
      bus.psum_valid = 1'b0; cur_acc = 0;
   endtask

   task automatic start_row(input int np_in, input int rl_in);
      bus.start = 1'b1; bus.num_passes = PW'(np_in); bus.row_len = AW'(rl_in);
      tick();
      bus.start = 1'b0;
   endtask

   task automatic run_row(input int np_in, input int rl_in, input int n_send,
                          input bit gap, input bit exp_ovf);
      int np_eff, L, t_last, d0, s;
      logic signed [DW-1:0] w;
      np_eff = (np_in == 0) ? 1 : np_in;
      L = (rl_in == 0) ? 1 : ((rl_in > FS) ? FS : rl_in);
      for (int i = 0; i < L; i++) begin
         s = 0;
         for (int p = 0; p < np_eff; p++) s += vec[p][i];
         w = s[DW-1:0];
`ifdef PSUM_CTRL_RELU_EN
         if (w < 0) w = '0;
`endif
         exp_q.push_back(int'(w));
      end
      got.delete();
      start_row(np_in, rl_in);
      tick();
      for (int p = 0; p < np_eff; p++) begin
         drive_pass(p, n_send, L, gap, t_last);
         if (p < np_eff - 1)
            while (cyc < t_last + 4) tick();
      end
      d0 = done_cnt;
      for (int k = 0; k < 100 && done_cnt == d0; k++) tick();
      chk("done_seen", done_cnt - d0, 1);
      tick();
      chk("drain_count_left", exp_q.size(), 0);
      chk("ovf_err", bus.ovf_err, exp_ovf);
      chk("busy_idle", bus.busy, 0);
      exp_q.delete();
   endtask

   initial begin
      int t_last;
      bus.start = 0; bus.num_passes = '0; bus.row_len = '0;
      bus.psum_valid = 0; bus.psum_in = '0;
      repeat (3) @(posedge clk1);
      #1;
      chk("rst_busy", bus.busy, 0);
      chk("rst_ctrl", int'({bus.fifo_wr_clr, bus.fifo_rd_clr, bus.fifo_wr_en, bus.fifo_rd_en,
                            bus.fifo_re_buf, bus.out_valid, bus.done, bus.ovf_err}), 0);
      clr = 1'b0;
      chk_en = 1;
      tick();

      // 1: single pass
      vec[0] = '{1, 2, 3, 4, 0, 0, 0, 0, 0, 0};
      run_row(1, 4, 4, 0, 0);
      for (int i = 0; i < 4; i++) chk("t1_lit", got_at(i), i + 1);

      // 2: three passes of 10,-5,7
      for (int p = 0; p < 3; p++) vec[p] = '{10, -5, 7, 0, 0, 0, 0, 0, 0, 0};
      run_row(3, 3, 3, 0, 0);
      chk("t2_lit0", got_at(0), 30);
      chk("t2_lit1", got_at(1), -15);
      chk("t2_lit2", got_at(2), 21);

      // 3: gapped input, full FIFO, two passes, wrap-around add
      for (int i = 0; i < 10; i++) begin
         vec[0][i] = 100 * i - 450;
         vec[1][i] = 7 * i + 3;
      end
      vec[0][0] = 30000; vec[1][0] = 30000;
      run_row(2, 10, 10, 1, 0);
      chk("t3_wrap", got_at(0), -5536);
      chk("t3_last", got_at(9), 900 - 450 + 63 + 3);

      // 4: overflow, third psum ignored
      vec[0] = '{7, 8, 9, 0, 0, 0, 0, 0, 0, 0};
      run_row(1, 2, 3, 0, 1);
      chk("t4_lit0", got_at(0), 7);
      chk("t4_lit1", got_at(1), 8);
      tick();
      chk("t4_sticky", bus.ovf_err, 1);

      // 5: reset in pass 1 after two writes, then restart
      vec[0] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
      vec[1] = '{2, 2, 0, 0, 0, 0, 0, 0, 0, 0};
      start_row(2, 4);
      chk("t5_ovf_cleared", bus.ovf_err, 0);
      tick();
      drive_pass(0, 4, 4, 0, t_last);
      while (cyc < t_last + 4) tick();
      drive_pass(1, 2, 4, 0, t_last);
      tick(); tick();
      clr = 1'b1;
      tick();
      chk("t5_clr_busy", bus.busy, 0);
      chk("t5_clr_ctrl", int'({bus.fifo_wr_clr, bus.fifo_rd_clr, bus.fifo_wr_en, bus.fifo_rd_en,
                               bus.fifo_re_buf, bus.out_valid, bus.done, bus.ovf_err}), 0);
      tick();
      clr = 1'b0;
      tick();
      vec[0] = '{5, 6, 0, 0, 0, 0, 0, 0, 0, 0};
      run_row(1, 2, 2, 0, 0);
      chk("t5_lit0", got_at(0), 5);
      chk("t5_lit1", got_at(1), 6);

      // 6: negative result, clamped only when ReLU is built in
      vec[0] = '{-3, 4, 0, 0, 0, 0, 0, 0, 0, 0};
      run_row(1, 2, 2, 0, 0);
`ifdef PSUM_CTRL_RELU_EN
      chk("t6_lit0", got_at(0), 0);
`else
      chk("t6_lit0", got_at(0), -3);
`endif
      chk("t6_lit1", got_at(1), 4);

      // 7: row_len above FIFO_SIZE clamps and flags
      for (int i = 0; i < 10; i++) vec[0][i] = i + 1;
      run_row(1, 15, 10, 0, 1);
      chk("t7_last", got_at(9), 10);

      // 8: row_len 0 and num_passes 0 both behave as 1
      vec[0] = '{42, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      run_row(0, 0, 1, 0, 0);
      chk("t8_lit", got_at(0), 42);
      chk("t8_count", got.size(), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
